alu_mb_seq_6502: RTL and testbench
==================================

Name: alu_mb_seq_6502

Overview:
Multi-byte operation sequencer for the 8-bit 6502 ALU, which is instantiated externally. It accepts one N-byte command over a valid/ready handshake and issues it to the ALU one byte per cycle, chaining the ALU's registered carry-out into the next byte's carry-in. It collects the result bytes and flags and returns them over a valid/ready response. Used for 16/24/32-bit address arithmetic and multi-byte shifts/rotates without extra adders.

Parameters:
NBYTES, 2, operand width in bytes (legal 2..4)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous assert, active-low
rdy  in  1  global stall; low freezes sequencer and ALU
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  4  ALU op encoding (0011 add, 0111 sub, 1011 A+A, 11xx logic)
cmd_shr  in  1  right shift/rotate through carry (forces op 1111)
cmd_bcd  in  1  BCD carry mode, forwarded to ALU
cmd_ci  in  1  initial carry-in
cmd_a  in  8*NBYTES  operand A
cmd_b  in  8*NBYTES  operand B
alu_op  out  4  to ALU op
alu_right  out  1  to ALU right
alu_ai  out  8  to ALU AI
alu_bi  out  8  to ALU BI
alu_ci  out  1  to ALU CI
alu_bcd  out  1  to ALU BCD
alu_rdy  out  1  to ALU RDY
alu_out  in  8  from ALU OUT
alu_co  in  1  from ALU CO
alu_v  in  1  from ALU V
alu_n  in  1  from ALU N
rsp_valid  out  1  result valid
rsp_ready  in  1  result consumed when valid&ready
rsp_data  out  8*NBYTES  result
rsp_c  out  1  final carry
rsp_v  out  1  overflow (MSB byte)
rsp_n  out  1  result bit 8*NBYTES-1
rsp_z  out  1  whole result zero

Behaviour:
- Reset values: state IDLE, cmd_ready=1, rsp_valid=0, rsp_data=0, all rsp flags 0, alu_rdy=0, all other alu_* outputs 0.
- ALU contract: a byte is issued in a cycle with alu_rdy=1. Its result and flags are visible on alu_out/alu_co/alu_v/alu_n in the next cycle.
- States:
  - IDLE: cmd_ready=rdy. Accept latches the command and byte index idx=0, then goes to ISSUE.
  - ISSUE: one byte per cycle while rdy. alu_rdy=rdy.
    - Byte order: LSB-first, or MSB-first when cmd_shr=1.
    - alu_ci = cmd_ci on the first byte, alu_co on later bytes.
    - Result of the previous byte is captured from alu_out in the same cycle.
    - After NBYTES issues, go to CAPTURE.
  - CAPTURE: alu_rdy=0. Capture the last byte and set rsp_c=alu_co. Go to DONE.
  - DONE: rsp_valid=1, outputs held stable until rsp_ready. Then go to IDLE.
- Latency: accept to rsp_valid is NBYTES+2 cycles with rdy continuously high. One command per NBYTES+3 cycles.
- Shift mode (cmd_shr=1): alu_op=1111, alu_right=1, alu_bi=0.
  - ALU CO is the byte's bit0, chained to the next lower byte.
  - rsp_c is the bit shifted out of byte 0.
  - rsp_v=0.
- Other modes: alu_op=cmd_op, alu_right=0.
  - rsp_v and rsp_n are sampled from alu_v and alu_n when the MSB byte result is visible.
- rsp_z: AND over all bytes of (alu_out==0).
- rsp_n in shift mode: taken from the MSB-byte result.
- BCD: cmd_bcd is forwarded only. Decimal correction of result bytes is out of scope; rsp_c is the BCD carry.
- rdy low:
  - All state, idx and partial results freeze, and alu_rdy=0, so the ALU registers hold.
  - The pending-capture byte is captured on the first cycle rdy returns high.
  - rsp_valid is unaffected by rdy.
- cmd_valid in any state other than IDLE is ignored (cmd_ready=0). No command can be accepted in the cycle the response completes.
- rst_n asserted mid-operation: immediate return to reset values and the partial result is discarded. The ALU is not reset.
- idx counter width is clog2(NBYTES). It wraps only through the IDLE reload.

Decomposition:
- Package alu_seq_pkg:
  - state enum (IDLE, ISSUE, CAPTURE, DONE)
  - op constants OP_ADD=4'b0011, OP_SUB=4'b0111, OP_ASL=4'b1011, OP_OR=4'b1100, OP_AND=4'b1101, OP_EOR=4'b1110, OP_PASS=4'b1111
- No sub-module: the byte-select mux and capture demux stay inline. The ALU is instantiated by the parent.

Test Plan:
- NBYTES=2, add 0x12FF+0x0001, ci=0 -> rsp_data=0x1300, c=0, z=0, n=0, v=0, rsp_valid exactly 4 cycles after accept.
- Sub 0x0000-0x0001, ci=1 -> 0xFFFF, c=0, n=1, z=0. Sub 0x1234-0x1234, ci=1 -> 0x0000, c=1, z=1.
- Left shift op 1011, A=0x8080, ci=0 -> 0x0100, c=1, z=0. Right shift cmd_shr=1, A=0x8001, ci=1 -> 0xC000, c=1, n=1, v=0.
- Overflow: add 0x7FFF+0x0001 -> 0x8000, v=1, n=1, c=0.
- rdy low for 3 cycles after the first byte issued -> alu_rdy=0 throughout the stall, same result 0x1300, latency +3. Also hold rsp_ready low 5 cycles -> rsp_* stable and cmd_ready=0 throughout.
- rst_n low during ISSUE -> rsp_valid=0, cmd_ready=1 next cycle. A following add 0x0001+0x0001 -> 0x0002, with no stale carry.

Source files
------------

// File: rtl/alu_mb_seq_6502_pkg.sv
// Shared definitions for the multi-byte 6502 ALU sequencer.
//   seq_state_e : sequencer states (IDLE, ISSUE, CAPTURE, DONE)
//   OP_*        : 4-bit ALU op encodings
//   byte_pos()  : maps an issue index to the operand byte it addresses
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } seq_state_e;

  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_ASL  = 4'b1011;
  localparam logic [3:0] OP_OR   = 4'b1100;
  localparam logic [3:0] OP_AND  = 4'b1101;
  localparam logic [3:0] OP_EOR  = 4'b1110;
  localparam logic [3:0] OP_PASS = 4'b1111;

  // Issue index -> byte lane. Right shifts walk MSB-first so the bit
  // dropped out of each byte becomes the carry-in of the next lower one.
  function automatic int byte_pos(input int issue_idx, input logic msb_first,
                                  input int nbytes);
    return msb_first ? (nbytes - 1 - issue_idx) : issue_idx;
  endfunction

endpackage

// File: rtl/alu_mb_seq_6502_if.sv
// Command / response channel bundle for alu_mb_seq_6502.
//   cmd_* : one N-byte command, valid/ready (master drives, slave accepts)
//   rsp_* : result bytes and flags, valid/ready (slave drives, master consumes)
interface alu_mb_seq_6502_if #(
  parameter int NBYTES = 2
);
  import alu_seq_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [3:0]            cmd_op;
  logic                  cmd_shr;
  logic                  cmd_bcd;
  logic                  cmd_ci;
  logic [8*NBYTES-1:0]   cmd_a;
  logic [8*NBYTES-1:0]   cmd_b;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [8*NBYTES-1:0]   rsp_data;
  logic                  rsp_c;
  logic                  rsp_v;
  logic                  rsp_n;
  logic                  rsp_z;

  modport master (
    output cmd_valid, cmd_op, cmd_shr, cmd_bcd, cmd_ci, cmd_a, cmd_b,
    input  cmd_ready,
    input  rsp_valid, rsp_data, rsp_c, rsp_v, rsp_n, rsp_z,
    output rsp_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_shr, cmd_bcd, cmd_ci, cmd_a, cmd_b,
    output cmd_ready,
    output rsp_valid, rsp_data, rsp_c, rsp_v, rsp_n, rsp_z,
    input  rsp_ready
  );

endinterface

// File: rtl/alu_mb_seq_6502.sv
// Multi-byte operation sequencer for an external 8-bit 6502 ALU.
// Accepts one NBYTES-wide command, feeds the ALU one byte per cycle with
// the registered carry chained between bytes, gathers result bytes/flags
// and presents them on the response channel.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   rdy        : global stall; low freezes the sequencer and the ALU
//   bus        : command/response channels (slave side)
//   alu_*      : outputs drive the ALU inputs; alu_out/co/v/n are its
//                registered results, valid the cycle after an issue
module alu_mb_seq_6502
  import alu_seq_pkg::*;
#(
  parameter int NBYTES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  alu_mb_seq_6502_if.slave  bus,
  output logic [3:0]        alu_op,
  output logic              alu_right,
  output logic [7:0]        alu_ai,
  output logic [7:0]        alu_bi,
  output logic              alu_ci,
  output logic              alu_bcd,
  output logic              alu_rdy,
  input  logic [7:0]        alu_out,
  input  logic              alu_co,
  input  logic              alu_v,
  input  logic              alu_n
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);

  seq_state_e       state_reg, state_next;
  logic [IW-1:0]    idx_reg, idx_next;
  logic [3:0]       op_reg, op_next;
  logic             shr_reg, shr_next;
  logic             bcd_reg, bcd_next;
  logic             ci_reg, ci_next;
  logic [W-1:0]     a_reg, a_next;
  logic [W-1:0]     b_reg, b_next;
  logic [W-1:0]     data_reg, data_next;
  logic             c_reg, c_next;
  logic             v_reg, v_next;
  logic             n_reg, n_next;
  logic             z_reg, z_next;

  logic             capture;
  int               issue_pos;
  int               cap_idx;
  int               cap_pos;

  assign bus.cmd_ready = (state_reg == IDLE) && rdy;
  assign bus.rsp_valid = (state_reg == DONE);
  assign bus.rsp_data  = data_reg;
  assign bus.rsp_c     = c_reg;
  assign bus.rsp_v     = v_reg;
  assign bus.rsp_n     = n_reg;
  assign bus.rsp_z     = z_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      op_reg    <= '0;
      shr_reg   <= 1'b0;
      bcd_reg   <= 1'b0;
      ci_reg    <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      data_reg  <= '0;
      c_reg     <= 1'b0;
      v_reg     <= 1'b0;
      n_reg     <= 1'b0;
      z_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      op_reg    <= op_next;
      shr_reg   <= shr_next;
      bcd_reg   <= bcd_next;
      ci_reg    <= ci_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      data_reg  <= data_next;
      c_reg     <= c_next;
      v_reg     <= v_next;
      n_reg     <= n_next;
      z_reg     <= z_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    op_next    = op_reg;
    shr_next   = shr_reg;
    bcd_next   = bcd_reg;
    ci_next    = ci_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    data_next  = data_reg;
    c_next     = c_reg;
    v_next     = v_reg;
    n_next     = n_reg;
    z_next     = z_reg;

    alu_op     = 4'b0000;
    alu_right  = 1'b0;
    alu_ai     = 8'h00;
    alu_bi     = 8'h00;
    alu_ci     = 1'b0;
    alu_bcd    = 1'b0;
    alu_rdy    = 1'b0;
    capture    = 1'b0;

    issue_pos = byte_pos(int'(idx_reg), shr_reg, NBYTES);
    // In ISSUE the byte visible on alu_out belongs to the previous index;
    // in CAPTURE it belongs to the last index, which idx still holds.
    if (state_reg == CAPTURE || idx_reg == '0)
      cap_idx = int'(idx_reg);
    else
      cap_idx = int'(idx_reg) - 1;
    cap_pos = byte_pos(cap_idx, shr_reg, NBYTES);

    case (state_reg)
      IDLE: begin
        if (rdy && bus.cmd_valid) begin
          op_next    = bus.cmd_op;
          shr_next   = bus.cmd_shr;
          bcd_next   = bus.cmd_bcd;
          ci_next    = bus.cmd_ci;
          a_next     = bus.cmd_a;
          b_next     = bus.cmd_b;
          idx_next   = '0;
          c_next     = 1'b0;
          v_next     = 1'b0;
          n_next     = 1'b0;
          z_next     = 1'b1;
          state_next = ISSUE;
        end
      end

      ISSUE: begin
        alu_rdy   = rdy;
        alu_op    = shr_reg ? OP_PASS : op_reg;
        alu_right = shr_reg;
        alu_ai    = a_reg[8*issue_pos +: 8];
        alu_bi    = shr_reg ? 8'h00 : b_reg[8*issue_pos +: 8];
        alu_ci    = (idx_reg == '0) ? ci_reg : alu_co;
        alu_bcd   = bcd_reg;
        if (rdy) begin
          capture = (idx_reg != '0);
          if (idx_reg == IW'(NBYTES - 1))
            state_next = CAPTURE;
          else
            idx_next = idx_reg + IW'(1);
        end
      end

      CAPTURE: begin
        if (rdy) begin
          capture    = 1'b1;
          c_next     = alu_co;
          state_next = DONE;
        end
      end

      DONE: begin
        if (bus.rsp_ready)
          state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase

    if (capture) begin
      data_next[8*cap_pos +: 8] = alu_out;
      if (alu_out != 8'h00)
        z_next = 1'b0;
      // Sign/overflow come from whichever issue produced the MSB byte.
      if (cap_pos == NBYTES - 1) begin
        n_next = alu_n;
        v_next = shr_reg ? 1'b0 : alu_v;
      end
    end
  end

endmodule

// File: tb/tb_alu_mb_seq_6502.sv
// Scoreboard bench for alu_mb_seq_6502 with a behavioural byte ALU and a
// whole-width arithmetic reference model.
module tb_alu_mb_seq_6502;
  import alu_seq_pkg::*;

  localparam int NBYTES = 2;
  localparam int W      = 8 * NBYTES;

  typedef struct {
    logic [31:0] data;
    logic        c;
    logic        v;
    logic        n;
    logic        z;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic [3:0]  alu_op;
  logic        alu_right;
  logic [7:0]  alu_ai;
  logic [7:0]  alu_bi;
  logic        alu_ci;
  logic        alu_bcd;
  logic        alu_rdy;
  logic [7:0]  alu_out = 8'h00;
  logic        alu_co  = 1'b0;
  logic        alu_v   = 1'b0;
  logic        alu_n   = 1'b0;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   hold_req = 0;
  bit   rand_ready = 0;
  logic cur_bcd = 1'b0;
  logic cur_shr = 1'b0;
  exp_t exp_q[$];
  int   rsp_cnt = 0;

  alu_mb_seq_6502_if #(.NBYTES(NBYTES)) bus ();

  alu_mb_seq_6502 #(.NBYTES(NBYTES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rdy       (rdy),
    .bus       (bus.slave),
    .alu_op    (alu_op),
    .alu_right (alu_right),
    .alu_ai    (alu_ai),
    .alu_bi    (alu_bi),
    .alu_ci    (alu_ci),
    .alu_bcd   (alu_bcd),
    .alu_rdy   (alu_rdy),
    .alu_out   (alu_out),
    .alu_co    (alu_co),
    .alu_v     (alu_v),
    .alu_n     (alu_n)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural 8-bit ALU: registered results, holds while alu_rdy is low.
  initial forever begin
    logic [8:0] s;
    logic [7:0] x;
    @(posedge clk);
    if (alu_rdy) begin
      if (alu_right) begin
        alu_out <= {alu_ci, alu_ai[7:1]};
        alu_co  <= alu_ai[0];
        alu_v   <= 1'b0;
        alu_n   <= alu_ci;
      end else begin
        case (alu_op)
          OP_ADD, OP_SUB, OP_ASL: begin
            x = (alu_op == OP_ADD) ? alu_bi : (alu_op == OP_SUB) ? ~alu_bi : alu_ai;
            s = {1'b0, alu_ai} + {1'b0, x} + {8'h00, alu_ci};
            alu_out <= s[7:0];
            alu_co  <= s[8];
            alu_v   <= (alu_ai[7] == x[7]) && (s[7] != alu_ai[7]);
            alu_n   <= s[7];
          end
          default: begin
            case (alu_op)
              OP_OR:   x = alu_ai | alu_bi;
              OP_AND:  x = alu_ai & alu_bi;
              OP_EOR:  x = alu_ai ^ alu_bi;
              default: x = alu_ai;
            endcase
            alu_out <= x;
            alu_co  <= 1'b0;
            alu_v   <= 1'b0;
            alu_n   <= x[7];
          end
        endcase
      end
    end
  end

  // Whole-width reference: the N-byte result as one wide operation.
  function automatic exp_t ref_model(input logic [63:0] a_in, input logic [63:0] b_in,
                                     input logic [3:0] op, input logic shr, input logic ci);
    exp_t        e;
    logic [63:0] mask, a, b, x, r, full;
    bit          arith;
    mask = (64'd1 << W) - 64'd1;
    a = a_in & mask;
    b = b_in & mask;
    e = '{data: 32'd0, c: 1'b0, v: 1'b0, n: 1'b0, z: 1'b0, lat: 0, acc: 0};
    arith = 0;
    x = 64'd0;
    r = 64'd0;
    if (shr) begin
      r   = (64'(ci) << (W - 1)) | (a >> 1);
      e.c = a[0];
    end else begin
      case (op)
        OP_ADD:  begin x = b;          arith = 1; end
        OP_SUB:  begin x = ~b & mask;  arith = 1; end
        OP_ASL:  begin x = a;          arith = 1; end
        OP_OR:   r = a | b;
        OP_AND:  r = a & b;
        OP_EOR:  r = a ^ b;
        default: r = a;
      endcase
    end
    if (arith) begin
      full = a + x + 64'(ci);
      r    = full & mask;
      e.c  = full[W];
      e.v  = (a[W-1] == x[W-1]) && (r[W-1] != a[W-1]);
    end
    e.data = 32'(r);
    e.n    = r[W-1];
    e.z    = (r == 64'd0);
    return e;
  endfunction

  // Issue one command; optional rdy stall of 'stall' cycles starting
  // right after the first byte has gone to the ALU.
  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op,
                      input logic shr, input logic bcd, input logic ci, input int stall);
    exp_t e;
    int   n;
    e = ref_model(a, b, op, shr, ci);
    e.lat = NBYTES + 2 + stall;
    bus.cmd_a     = a[W-1:0];
    bus.cmd_b     = b[W-1:0];
    bus.cmd_op    = op;
    bus.cmd_shr   = shr;
    bus.cmd_bcd   = bcd;
    bus.cmd_ci    = ci;
    bus.cmd_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cmd_ready && n < 200);
    if (!bus.cmd_ready) begin
      chk("cmd_accept_timeout", 64'd0, 64'd1);
      bus.cmd_valid = 1'b0;
      return;
    end
    e.acc   = cyc;
    cur_bcd = bcd;
    cur_shr = shr;
    exp_q.push_back(e);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    if (stall > 0) begin
      @(posedge clk);
      #1 rdy = 1'b0;
      repeat (stall) @(posedge clk);
      #1 rdy = 1'b1;
    end
  endtask

  // rsp_ready driver: directed holds, optional random back-pressure.
  initial begin
    bus.rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (hold_req > 0 && bus.rsp_valid) begin
        bus.rsp_ready = 1'b0;
        hold_req--;
      end else if (rand_ready) begin
        bus.rsp_ready = ($urandom_range(0, 3) != 0);
      end else begin
        bus.rsp_ready = 1'b1;
      end
    end
  end

  // Monitor: latency, stability while waiting, final comparison on handshake.
  initial begin
    bit          in_rsp;
    logic [31:0] h_data;
    logic [3:0]  h_flags;
    exp_t        e;
    in_rsp = 0;
    h_data = '0;
    h_flags = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (!rdy) begin
          chk("alu_rdy_in_stall", 64'(alu_rdy), 64'd0);
          chk("cmd_ready_in_stall", 64'(bus.cmd_ready), 64'd0);
        end
        if (alu_rdy) begin
          chk("alu_bcd_fwd", 64'(alu_bcd), 64'(cur_bcd));
          chk("alu_right", 64'(alu_right), 64'(cur_shr));
        end
        if (bus.rsp_valid) begin
          chk("cmd_ready_in_done", 64'(bus.cmd_ready), 64'd0);
          if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 64'd1, 64'd0);
          end else if (!in_rsp) begin
            in_rsp  = 1;
            h_data  = 32'(bus.rsp_data);
            h_flags = {bus.rsp_c, bus.rsp_v, bus.rsp_n, bus.rsp_z};
            chk("latency", 64'(cyc - exp_q[0].acc), 64'(exp_q[0].lat));
          end else begin
            chk("rsp_data_stable", 64'(bus.rsp_data), 64'(h_data));
            chk("rsp_flags_stable", 64'({bus.rsp_c, bus.rsp_v, bus.rsp_n, bus.rsp_z}), 64'(h_flags));
          end
          if (bus.rsp_ready && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            in_rsp = 0;
            rsp_cnt++;
            $display("rsp %0d: data=%h c=%b v=%b n=%b z=%b (exp %h c=%b v=%b n=%b z=%b)",
                     rsp_cnt, bus.rsp_data, bus.rsp_c, bus.rsp_v, bus.rsp_n, bus.rsp_z,
                     e.data[W-1:0], e.c, e.v, e.n, e.z);
            chk("rsp_data", 64'(bus.rsp_data), 64'(e.data[W-1:0]));
            chk("rsp_c", 64'(bus.rsp_c), 64'(e.c));
            chk("rsp_v", 64'(bus.rsp_v), 64'(e.v));
            chk("rsp_n", 64'(bus.rsp_n), 64'(e.n));
            chk("rsp_z", 64'(bus.rsp_z), 64'(e.z));
          end
        end
      end
    end
  end

  initial begin
    logic [3:0] ops [7];
    int         st;
    ops = '{OP_ADD, OP_SUB, OP_ASL, OP_OR, OP_AND, OP_EOR, OP_PASS};
    rst_n = 1'b0;
    rdy   = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 4'h0;
    bus.cmd_shr   = 1'b0;
    bus.cmd_bcd   = 1'b0;
    bus.cmd_ci    = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    repeat (2) @(negedge clk);
    chk("reset_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset_rsp_data", 64'(bus.rsp_data), 64'd0);
    chk("reset_rsp_flags", 64'({bus.rsp_c, bus.rsp_v, bus.rsp_n, bus.rsp_z}), 64'd0);
    chk("reset_alu_rdy", 64'(alu_rdy), 64'd0);
    chk("reset_alu_outs", 64'({alu_op, alu_right, alu_ai, alu_bi, alu_ci, alu_bcd}), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    send(64'h12FF, 64'h0001, OP_ADD, 1'b0, 1'b0, 1'b0, 0);
    send(64'h0000, 64'h0001, OP_SUB, 1'b0, 1'b0, 1'b1, 0);
    send(64'h1234, 64'h1234, OP_SUB, 1'b0, 1'b0, 1'b1, 0);
    send(64'h8080, 64'h0000, OP_ASL, 1'b0, 1'b0, 1'b0, 0);
    send(64'h8001, 64'h5A5A, OP_ADD, 1'b1, 1'b0, 1'b1, 0);
    send(64'h7FFF, 64'h0001, OP_ADD, 1'b0, 1'b1, 1'b0, 0);
    send(64'h12FF, 64'h0001, OP_ADD, 1'b0, 1'b0, 1'b0, 3);
    hold_req = 5;
    send(64'h0102, 64'h0304, OP_ADD, 1'b0, 1'b0, 1'b0, 0);

    // Abort after the low byte (which leaves ALU carry set) has issued.
    send(64'h12FF, 64'h0001, OP_ADD, 1'b0, 1'b0, 1'b0, 0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clk);
    chk("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("abort_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("abort_rsp_data", 64'(bus.rsp_data), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(64'h0001, 64'h0001, OP_ADD, 1'b0, 1'b0, 1'b0, 0);

    rand_ready = 1;
    for (int i = 0; i < 40; i++) begin
      st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      send({32'd0, $urandom}, {32'd0, $urandom}, ops[$urandom_range(0, 6)],
           logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 1)), st);
    end

    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0)
      chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
